// File: rtl/shift_sin_pout_sync_bit.sv
// Multi-flop synchronizer for one asynchronous input bit.
// The output is the last flop of a DEPTH-long chain that clears on reset.
module sync_bit #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/shift_sin_pout.sv
// Serial-in / parallel-out receiver for an externally clocked MSB-first link,
// with a single holding register, full/overrun flags and host acknowledge.
module shift_sin_pout #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             sclk,
  input  logic             sin,
  input  logic             data_ack,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             full,
  output logic             overrun,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  logic             cs_sync, sclk_sync, sin_sync;
  logic             sclk_prev_q;
  logic             shift_evt_q, sin_evt_q;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dv_q, dv_d;
  logic             full_q, full_d;
  logic             ovr_q, ovr_d;
  logic             busy_q;
  logic             word_done;

  // Synchronizers: sin uses the same depth as sclk so the sampled bit stays aligned
  sync_bit #(.DEPTH(SYNC_STAGES)) u_sync_cs   (.clk(clk), .rst(rst), .d_i(cs),   .q_o(cs_sync));
  sync_bit #(.DEPTH(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst(rst), .d_i(sclk), .q_o(sclk_sync));
  sync_bit #(.DEPTH(SYNC_STAGES)) u_sync_sin  (.clk(clk), .rst(rst), .d_i(sin),  .q_o(sin_sync));

  // Edge detect: rising sclk inside a frame is registered together with its data bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      shift_evt_q <= 1'b0;
      sin_evt_q   <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_sync;
      shift_evt_q <= sclk_sync & ~sclk_prev_q & cs_sync;
      sin_evt_q   <= sin_sync;
    end
  end

  // Assembly and holding-register update
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    full_d    = full_q;
    ovr_d     = ovr_q;
    word_done = 1'b0;

    if (!cs_sync) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_evt_q) begin
      shift_d = {shift_q[WIDTH-2:0], sin_evt_q};
      if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        word_done = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // A same-cycle ack retires the old word, so it cancels the overrun instead of raising it
    if (word_done) begin
      data_d = shift_d;
      dv_d   = 1'b1;
      full_d = 1'b1;
      if (full_q) begin
        ovr_d = ~data_ack;
      end
    end else if (data_ack && full_q) begin
      full_d = 1'b0;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
      busy_q  <= (cnt_d != '0);
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign full       = full_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_shift_sin_pout.sv
// Self-checking bench for shift_sin_pout: directed scenarios plus randomized
// words, acks and aborted frames checked against a word-level model.
module tb_shift_sin_pout;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst, cs, sclk, sin, data_ack;
  logic [WIDTH-1:0] data;
  logic             data_valid, full, overrun, busy;

  int tests = 0;
  int fails = 0;
  int dv_seen = 0;

  // Word-level model of the receiver
  logic [WIDTH-1:0] m_acc, m_data;
  logic             m_full, m_ovr;
  int               m_nbits, m_words;

  shift_sin_pout #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .sin(sin), .data_ack(data_ack),
    .data(data), .data_valid(data_valid), .full(full), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (data_valid) dv_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = '0; m_data = '0; m_full = 1'b0; m_ovr = 1'b0; m_nbits = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".data"},    32'(data),    32'(m_data));
    check({tag, ".full"},    32'(full),    32'(m_full));
    check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    check({tag, ".busy"},    32'(busy),    32'(m_nbits != 0));
    check({tag, ".words"},   32'(dv_seen), 32'(m_words));
  endtask

  // One serial bit: sclk rises just after a clk edge and stays high long enough
  // to see whether data_valid fires exactly SYNC+2 cycles later.
  task automatic send_bit(input logic b, input logic ack_done);
    logic completes;
    sin = b;
    repeat (3) tick();
    sclk = 1'b1;
    completes = (m_nbits == WIDTH - 1);
    for (int k = 1; k <= SYNC + 3; k++) begin
      tick();
      check("dv_timing", 32'(data_valid), 32'(completes && k == SYNC + 2));
      if (ack_done && k == SYNC + 1) data_ack = 1'b1;
      if (k == SYNC + 2) data_ack = 1'b0;
    end
    sclk = 1'b0;
    m_acc = {m_acc[WIDTH-2:0], b};
    m_nbits++;
    if (m_nbits == WIDTH) begin
      if (m_full) m_ovr = !ack_done;
      m_full = 1'b1;
      m_data = m_acc;
      m_nbits = 0;
      m_words++;
    end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic ack_done);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i], ack_done && i == 0);
  endtask

  task automatic pulse_ack();
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    tick();
    if (m_full) begin
      m_full = 1'b0;
      m_ovr  = 1'b0;
    end
  endtask

  task automatic drop_cs(input int cycles);
    cs = 1'b0;
    repeat (cycles) tick();
    m_nbits = 0;
    cs = 1'b1;
    repeat (SYNC + 2) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    rst = 1'b1; cs = 1'b0; sclk = 1'b0; sin = 1'b0; data_ack = 1'b0;
    m_words = 0;
    model_reset();
    repeat (3) tick();
    check("reset.data",  32'(data),       32'h0);
    check("reset.dv",    32'(data_valid), 32'h0);
    check("reset.full",  32'(full),       32'h0);
    check("reset.ovr",   32'(overrun),    32'h0);
    check("reset.busy",  32'(busy),       32'h0);
    rst = 1'b0;
    cs  = 1'b1;
    repeat (SYNC + 2) tick();

    // Plain word
    send_word(8'hA5, 1'b0);
    check_state("a5");
    pulse_ack();

    // Aborted partial frame then a full word
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    check("partial.busy", 32'(busy), 32'h1);
    drop_cs(4);
    check("dropped.busy", 32'(busy), 32'h0);
    send_word(8'h3C, 1'b0);
    check_state("3c");

    // Overrun then ack
    pulse_ack();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    check_state("ovr");
    pulse_ack();
    check_state("ovr_ack");

    // Ack coinciding with completion
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b1);
    check_state("ack_same");
    pulse_ack();

    // Reset mid-word with cs held high
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    do_reset();
    check_state("midrst");
    repeat (SYNC + 2) tick();
    send_word(8'h81, 1'b0);
    check_state("81");

    // sclk activity outside a frame
    cs = 1'b0;
    repeat (SYNC + 2) tick();
    held = data;
    for (int i = 0; i < 16; i++) begin
      sclk = ~sclk;
      repeat (2) tick();
    end
    sclk = 1'b0;
    repeat (SYNC + 3) tick();
    check("nocs.data", 32'(data), 32'(held));
    check_state("nocs");
    cs = 1'b1;
    repeat (SYNC + 2) tick();

    // Randomized mix of words, acks and aborted frames
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0, 1: send_word(WIDTH'($urandom), ($urandom_range(0, 3) == 0));
        2:    pulse_ack();
        default: begin
          int nb;
          nb = $urandom_range(1, WIDTH - 1);
          for (int i = 0; i < nb; i++) send_bit(1'($urandom), 1'b0);
          check("rnd.busy", 32'(busy), 32'h1);
          drop_cs($urandom_range(SYNC + 1, SYNC + 5));
        end
      endcase
      check_state("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_sin_pout.md
SHIFT_SIN_POUT -- requirements
Module: shift_sin_pout

Interface
REQ-001 Parameter WIDTH, default 8: serial word length in bits, minimum 2.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for the external serial pins, minimum 2.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cs  input  1  asynchronous frame enable from the remote transmitter; high means a frame is in progress.
REQ-006 sclk  input  1  asynchronous serial shift clock; data is valid at its rising edge.
REQ-007 sin  input  1  asynchronous serial data, MSB first.
REQ-008 data_ack  input  1  host acknowledge; one-cycle pulse consumes the held word.
REQ-009 data  output  WIDTH  last completed word (holding register).
REQ-010 data_valid  output  1  one-cycle strobe when a word completes.
REQ-011 full  output  1  holding register contains an unacknowledged word.
REQ-012 overrun  output  1  sticky flag: a word completed while full was set.
REQ-013 busy  output  1  a partial word is being assembled (bit count nonzero).

Function
REQ-014 cs, sclk and sin shall each pass through SYNC_STAGES flops; sin shall use the same depth as sclk so sample alignment is preserved.
REQ-015 A shift event is a synchronized sclk transition 0->1 detected by a registered previous-value compare, occurring while the synchronized cs is 1.
REQ-016 On each shift event the shift register shall load {shift[WIDTH-2:0], sin_sync} and the bit counter shall increment, modulo WIDTH.
REQ-017 When the shift event that brings the count to WIDTH occurs, on the next clock: data = the assembled word, data_valid = 1 for exactly one cycle, full = 1, bit counter = 0.
REQ-018 Latency from the sclk pin edge of the final bit to data_valid shall be SYNC_STAGES+2 clk cycles, fixed.
REQ-019 If synchronized cs is 0, the bit counter and shift register shall clear on every cycle; a partial word is discarded silently; data, full and overrun are unaffected.
REQ-020 sclk edges while synchronized cs is 0 shall be ignored.
REQ-021 data_ack while full = 1: full clears, and overrun clears, on the next clock.
REQ-022 data_ack while full = 0 shall have no effect.
REQ-023 Word completion while full = 1 and no data_ack in the same cycle: data is overwritten with the new word, full stays 1, and overrun sets.
REQ-024 Word completion and data_ack in the same cycle: the ack applies to the old word; the new word loads; full stays 1; overrun is not set.
REQ-025 busy = (bit counter != 0), registered.
REQ-026 data shall change only on word completion or reset.

Reset
REQ-027 While rst = 1 on a clk edge: data = 0, data_valid = 0, full = 0, overrun = 0, busy = 0, bit counter = 0, shift register = 0, and all synchronizer and edge-detect flops = 0.
REQ-028 Reset asserted mid-word shall discard the partial word; the first shift event after reset counts as bit 0 even if cs stays high.
REQ-029 A shift event in the same cycle as rst shall be ignored.

Structure
REQ-030 No shared package; WIDTH and SYNC_STAGES are module parameters only; the bit counter width is $clog2(WIDTH).
REQ-031 One sub-module, sync_bit (parameterised depth, synchronous reset), shall be instantiated three times for cs, sclk and sin.

Verification
REQ-032 Reset, then cs=1, shift 8'hA5 MSB first -> one data_valid pulse SYNC_STAGES+2 cycles after the 8th sclk edge, data=8'hA5, full=1, overrun=0, busy=0.
REQ-033 Shift 3 bits, drop cs for 4 cycles, raise cs, shift 8'h3C -> data=8'h3C, single data_valid, no stray word.
REQ-034 Receive 8'h11, no ack, receive 8'h22 -> data=8'h22, full=1, overrun=1; then pulse data_ack -> full=0, overrun=0.
REQ-035 Receive 8'h11, pulse data_ack in the exact completion cycle of 8'h22 -> data=8'h22, full=1, overrun=0.
REQ-036 Assert rst after 5 bits of 8'hFF with cs held high, then shift 8'h81 -> data=8'h81, all flags as in REQ-032.
REQ-037 Toggle sclk with cs=0 for 16 edges -> no data_valid, busy=0, data unchanged.
